// File: rtl/mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_stage                                                       |
// | Function : EX/MEM pipeline register and data-memory access stage            |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module mem_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dMemWr,
  input  logic        dMemToReg,
  input  logic        dRegWrite,
  input  logic        dJal,
  input  logic        dLoadext,
  input  logic [1:0]  dDsize,
  input  logic [31:0] dALUout,
  input  logic [31:0] dBusB,
  input  logic [4:0]  dRw,
  input  logic [31:0] dDelayslot2,
  input  logic        memReady,
  input  logic [31:0] memRdata,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  output logic [3:0]  memBe,
  output logic        stall,
  output logic        buserr,
  output logic        RegWr,
  output logic        MemToReg,
  output logic        Jal,
  output logic [4:0]  Rw,
  output logic [31:0] ALUresult,
  output logic [31:0] MemData,
  output logic [31:0] Delayslot2
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ABORT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT);

  state_t           r_state, w_stateNext;
  logic [CNT_W-1:0] r_count, w_countNext;

  logic        r_memWr, r_memToReg, r_regWrite, r_jal, r_loadext;
  logic [1:0]  r_dsize;
  logic [31:0] r_aluOut, r_busB, r_delayslot2;
  logic [4:0]  r_rw;

  logic        w_memop;
  logic        w_stall;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_loadData;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_memWr      <= 1'b0;
      r_memToReg   <= 1'b0;
      r_regWrite   <= 1'b0;
      r_jal        <= 1'b0;
      r_loadext    <= 1'b0;
      r_dsize      <= 2'b00;
      r_aluOut     <= 32'h0;
      r_busB       <= 32'h0;
      r_rw         <= 5'd0;
      r_delayslot2 <= 32'h0;
    end else if (!w_stall) begin
      r_memWr      <= dMemWr;
      r_memToReg   <= dMemToReg;
      r_regWrite   <= dRegWrite;
      r_jal        <= dJal;
      r_loadext    <= dLoadext;
      r_dsize      <= dDsize;
      r_aluOut     <= dALUout;
      r_busB       <= dBusB;
      r_rw         <= dRw;
      r_delayslot2 <= dDelayslot2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_stateNext;
      r_count <= w_countNext;
    end
  end

  assign w_memop = r_memWr | r_memToReg;

  always_comb begin
    w_stateNext = r_state;
    w_countNext = r_count;
    w_stall     = 1'b0;
    memReq      = 1'b0;
    memWe       = 1'b0;
    buserr      = 1'b0;
    case (r_state)
      S_IDLE: begin
        memReq = w_memop;
        memWe  = r_memWr;
        if (w_memop && !memReady) begin
          w_stall     = 1'b1;
          w_countNext = CNT_W'(1);
          w_stateNext = S_WAIT;
        end
      end
      S_WAIT: begin
        memReq = 1'b1;
        memWe  = r_memWr;
        if (memReady) begin
          w_countNext = '0;
          w_stateNext = S_IDLE;
        end else begin
          w_stall = 1'b1;
          if (r_count == c_TIMEOUT) w_stateNext = S_ABORT;
          else                      w_countNext = r_count + CNT_W'(1);
        end
      end
      S_ABORT: begin
        // Aborted instruction leaves the stage with no write-back.
        buserr      = 1'b1;
        w_countNext = '0;
        w_stateNext = S_IDLE;
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  // Big-endian lanes: address offset 0 is bits 31:24.
  always_comb begin
    w_byte = memRdata[31:24];
    case (r_aluOut[1:0])
      2'd0:    w_byte = memRdata[31:24];
      2'd1:    w_byte = memRdata[23:16];
      2'd2:    w_byte = memRdata[15:8];
      default: w_byte = memRdata[7:0];
    endcase
    w_half = r_aluOut[1] ? memRdata[15:0] : memRdata[31:16];

    case (r_dsize)
      2'b10: begin
        memBe      = 4'b1000 >> r_aluOut[1:0];
        memWdata   = {4{r_busB[7:0]}};
        w_loadData = {{24{r_loadext & w_byte[7]}}, w_byte};
      end
      2'b01: begin
        memBe      = r_aluOut[1] ? 4'b0011 : 4'b1100;
        memWdata   = {2{r_busB[15:0]}};
        w_loadData = {{16{r_loadext & w_half[15]}}, w_half};
      end
      default: begin
        memBe      = 4'b1111;
        memWdata   = r_busB;
        w_loadData = memRdata;
      end
    endcase
    if (!w_memop) memBe = 4'b0000;
  end

  assign MemData    = r_memToReg ? w_loadData : 32'h0;
  assign memAddr    = {r_aluOut[31:2], 2'b00};
  assign stall      = w_stall;
  assign RegWr      = r_regWrite & ~w_stall & (r_state != S_ABORT);
  assign MemToReg   = r_memToReg;
  assign Jal        = r_jal;
  assign Rw         = r_rw;
  assign ALUresult  = r_aluOut;
  assign Delayslot2 = r_delayslot2;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// Testbench for mem_stage: directed cases plus randomized instructions checked
// against a lane/timing reference model.
module tb_mem_stage;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        dMemWr, dMemToReg, dRegWrite, dJal, dLoadext;
  logic [1:0]  dDsize;
  logic [31:0] dALUout, dBusB, dDelayslot2;
  logic [4:0]  dRw;
  logic        memReady;
  logic [31:0] memRdata;
  logic        memReq, memWe, stall, buserr, RegWr, MemToReg, Jal;
  logic [31:0] memAddr, memWdata, ALUresult, MemData, Delayslot2;
  logic [3:0]  memBe;
  logic [4:0]  Rw;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        wr, ld, re, jal, ext;
    logic [1:0]  sz;
    logic [31:0] alu, b, ds, rdata;
    logic [4:0]  rd;
  } instr_t;

  mem_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .dMemWr(dMemWr), .dMemToReg(dMemToReg), .dRegWrite(dRegWrite), .dJal(dJal),
    .dLoadext(dLoadext), .dDsize(dDsize), .dALUout(dALUout), .dBusB(dBusB),
    .dRw(dRw), .dDelayslot2(dDelayslot2), .memReady(memReady), .memRdata(memRdata),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
    .memBe(memBe), .stall(stall), .buserr(buserr), .RegWr(RegWr),
    .MemToReg(MemToReg), .Jal(Jal), .Rw(Rw), .ALUresult(ALUresult),
    .MemData(MemData), .Delayslot2(Delayslot2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: an access covers n bytes starting at lane f (lane 0 = MSB).
  function automatic int nBytes(input logic [1:0] sz);
    return (sz == 2'b10) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic int firstLane(input logic [1:0] sz, input logic [31:0] a);
    int n = nBytes(sz);
    int off = int'(a % 4);
    return (n == 1) ? off : (n == 2) ? (off / 2) * 2 : 0;
  endfunction

  function automatic logic [31:0] laneMask(input int n);
    return (n == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * n)) - 32'h1;
  endfunction

  function automatic logic [3:0] refBe(input instr_t in);
    logic [3:0] be = 4'b0000;
    int n = nBytes(in.sz);
    int f = firstLane(in.sz, in.alu);
    if (in.wr || in.ld)
      for (int i = f; i < f + n; i++) be[3 - i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] refWdata(input instr_t in);
    int n = nBytes(in.sz);
    logic [31:0] v = in.b & laneMask(n);
    logic [31:0] w = 32'h0;
    for (int j = 0; j < 4 / n; j++) w = w | (v << (8 * n * j));
    return w;
  endfunction

  function automatic logic [31:0] refLoad(input instr_t in);
    int n = nBytes(in.sz);
    int f = firstLane(in.sz, in.alu);
    logic [31:0] m = laneMask(n);
    logic [31:0] v = (in.rdata >> (8 * (4 - f - n))) & m;
    if (in.ext && n < 4 && v[8 * n - 1]) v = v | ~m;
    return v;
  endfunction

  function automatic instr_t mk(input logic wr, input logic ld, input logic re,
                                input logic ext, input logic [1:0] sz,
                                input logic [31:0] alu, input logic [31:0] b,
                                input logic [31:0] rdata);
    instr_t t;
    t.wr = wr; t.ld = ld; t.re = re; t.jal = 1'($urandom); t.ext = ext; t.sz = sz;
    t.alu = alu; t.b = b; t.rdata = rdata; t.ds = $urandom; t.rd = 5'($urandom);
    return t;
  endfunction

  function automatic instr_t randInstr();
    int kind = int'($urandom_range(0, 2));
    return mk(kind == 2, kind == 1, 1'($urandom), 1'($urandom), 2'($urandom),
              $urandom, $urandom, $urandom);
  endfunction

  // Issue one instruction; memReady stays low for w request cycles.
  task automatic runInstr(input instr_t in, input int w, input string tag);
    logic memop, ready, expStall, expAbort;
    int k;
    dMemWr = in.wr; dMemToReg = in.ld; dRegWrite = in.re; dJal = in.jal;
    dLoadext = in.ext; dDsize = in.sz; dALUout = in.alu; dBusB = in.b;
    dRw = in.rd; dDelayslot2 = in.ds;
    @(posedge clk); #1;
    memop = in.wr | in.ld;
    k = 1;
    check({tag, ".MemToReg"}, 32'(MemToReg), 32'(in.ld));
    check({tag, ".Jal"}, 32'(Jal), 32'(in.jal));
    check({tag, ".Delayslot2"}, Delayslot2, in.ds);
    forever begin
      ready    = (k > w);
      memReady = ready;
      memRdata = in.rdata;
      #1;
      expAbort = memop && (k == TIMEOUT + 2);
      expStall = memop && !ready && !expAbort;
      check({tag, ".memReq"}, 32'(memReq), 32'(memop && !expAbort));
      check({tag, ".stall"}, 32'(stall), 32'(expStall));
      check({tag, ".buserr"}, 32'(buserr), 32'(expAbort));
      check({tag, ".RegWr"}, 32'(RegWr), 32'(in.re && !expStall && !expAbort));
      check({tag, ".ALUresult"}, ALUresult, in.alu);
      check({tag, ".Rw"}, 32'(Rw), 32'(in.rd));
      if (!expStall && !expAbort) begin
        check({tag, ".memBe"}, 32'(memBe), 32'(refBe(in)));
        if (memop) begin
          check({tag, ".memAddr"}, memAddr, in.alu & 32'hFFFF_FFFC);
          check({tag, ".memWe"}, 32'(memWe), 32'(in.wr));
        end
        if (in.wr) check({tag, ".memWdata"}, memWdata, refWdata(in));
        if (in.ld) check({tag, ".MemData"}, MemData, refLoad(in));
      end
      if (!expStall) break;
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic checkCleared(input string tag);
    check({tag, ".memReq"}, 32'(memReq), 32'h0);
    check({tag, ".memWe"}, 32'(memWe), 32'h0);
    check({tag, ".stall"}, 32'(stall), 32'h0);
    check({tag, ".buserr"}, 32'(buserr), 32'h0);
    check({tag, ".RegWr"}, 32'(RegWr), 32'h0);
    check({tag, ".memBe"}, 32'(memBe), 32'h0);
    check({tag, ".memAddr"}, memAddr, 32'h0);
    check({tag, ".memWdata"}, memWdata, 32'h0);
    check({tag, ".MemData"}, MemData, 32'h0);
    check({tag, ".ALUresult"}, ALUresult, 32'h0);
    check({tag, ".Rw"}, 32'(Rw), 32'h0);
    check({tag, ".Delayslot2"}, Delayslot2, 32'h0);
    check({tag, ".Jal"}, 32'(Jal), 32'h0);
    check({tag, ".MemToReg"}, 32'(MemToReg), 32'h0);
  endtask

  initial begin
    instr_t t;
    int r, w;
    reset = 1'b1;
    dMemWr = 0; dMemToReg = 0; dRegWrite = 0; dJal = 0; dLoadext = 0; dDsize = 0;
    dALUout = 0; dBusB = 0; dRw = 0; dDelayslot2 = 0;
    memReady = 1'b1; memRdata = 32'hA5A5_5A5A;
    repeat (2) @(posedge clk);
    #1;
    checkCleared("reset");
    reset = 1'b0;

    runInstr(mk(1, 0, 0, 0, 2'b00, 32'h100, 32'hDEAD_BEEF, 32'h0), 0, "storeWord");
    runInstr(mk(0, 1, 1, 1, 2'b10, 32'h103, 32'h0, 32'h1122_33F0), 0, "loadByteSx");
    runInstr(mk(0, 1, 1, 0, 2'b01, 32'h102, 32'h0, 32'h1234_ABCD), 0, "loadHalfZx");
    runInstr(mk(0, 1, 1, 1, 2'b01, 32'h101, 32'h0, 32'h8765_4321), 0, "loadHalfHi");
    runInstr(mk(1, 0, 0, 0, 2'b10, 32'h202, 32'h0000_00C3, 32'h0), 0, "storeByte");
    runInstr(mk(0, 1, 1, 0, 2'b00, 32'h303, 32'h0, 32'hCAFE_F00D), 3, "loadWait3");
    runInstr(mk(0, 1, 1, 1, 2'b10, 32'h400, 32'h0, 32'h80FF_FFFF), TIMEOUT, "lastChance");
    runInstr(mk(0, 1, 1, 0, 2'b00, 32'h500, 32'h0, 32'h0), 1000, "timeout");
    runInstr(mk(0, 0, 1, 0, 2'b00, 32'h1234_5678, 32'h0, 32'h0), 0, "afterAbort");
    runInstr(mk(0, 0, 1, 0, 2'b10, 32'h0000_0003, 32'h0, 32'h0), 5, "aluReadyLow");

    for (int i = 0; i < 40; i++) begin
      t = randInstr();
      r = int'($urandom_range(0, 9));
      if (r < 5)       w = 0;
      else if (r < 8)  w = int'($urandom_range(1, 4));
      else if (r == 8) w = TIMEOUT;
      else             w = TIMEOUT + 1 + int'($urandom_range(0, 3));
      runInstr(t, w, "random");
    end

    // Reset while waiting on memory.
    t = mk(0, 1, 1, 0, 2'b00, 32'h600, 32'h0, 32'h0);
    dMemWr = t.wr; dMemToReg = t.ld; dRegWrite = t.re; dJal = t.jal;
    dLoadext = t.ext; dDsize = t.sz; dALUout = t.alu; dBusB = t.b;
    dRw = t.rd; dDelayslot2 = t.ds;
    @(posedge clk); #1;
    memReady = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("waitBeforeReset.memReq", 32'(memReq), 32'h1);
    check("waitBeforeReset.stall", 32'(stall), 32'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    checkCleared("resetInWait");
    reset = 1'b0;
    runInstr(mk(0, 0, 1, 1, 2'b00, 32'h7777_0000, 32'h0, 32'h0), 0, "afterReset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
